// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and sizing helper for the serial subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width that can hold 0..width-1, never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_sub_bit.sv
// rtl/full_sub_bit.sv - combinational full subtractor cell built from two half subtractors
module full_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.x(x),  .y(y),  .d(d1), .b(b1));
    half_subtractor u_hs1 (.x(d1), .y(bi), .d(d),  .b(b2));

    assign bo = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor, d = x - y
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    assign d = x ^ y;
    assign b = ~x & y;

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b - bin controller, LSB first, one bit per clock
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   res_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic               d_bit;
    logic               b_bit;
    logic               last;

    full_sub_bit u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (b_bit)
    );

    // New bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
    assign res_nxt = (res_sh >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        busy  = (state == RUN) || (state == DONE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_sh   <= a;
                b_sh   <= b;
                borrow <= bin;
                res_sh <= '0;
                cnt    <= '0;
            end
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt;
            borrow <= b_bit;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                diff <= res_nxt;
                bout <= b_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl at WIDTH 8, 4 and 1
module tb_serial_sub_ctrl;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       start_8 = 0, start_4 = 0, start_1 = 0;
    logic [7:0] a_8 = 0, b_8 = 0;
    logic [3:0] a_4 = 0, b_4 = 0;
    logic [0:0] a_1 = 0, b_1 = 0;
    logic       bin_8 = 0, bin_4 = 0, bin_1 = 0;
    logic       ready_8, busy_8, done_8, bout_8;
    logic       ready_4, busy_4, done_4, bout_4;
    logic       ready_1, busy_1, done_1, bout_1;
    logic [7:0] diff_8;
    logic [3:0] diff_4;
    logic [0:0] diff_1;

    exp_t        q8[$];
    exp_t        q4[$];
    exp_t        q1[$];
    logic [63:0] held_d [3] = '{0, 0, 0};
    logic        held_b [3] = '{0, 0, 0};
    logic        was_done [3] = '{0, 0, 0};
    int          widths [3] = '{8, 4, 1};

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_8), .a(a_8), .b(b_8), .bin(bin_8),
        .ready(ready_8), .busy(busy_8), .done(done_8), .diff(diff_8), .bout(bout_8));
    serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_4), .a(a_4), .b(b_4), .bin(bin_4),
        .ready(ready_4), .busy(busy_4), .done(done_4), .diff(diff_4), .bout(bout_4));
    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_1), .a(a_1), .b(b_1), .bin(bin_1),
        .ready(ready_1), .busy(busy_1), .done(done_1), .diff(diff_1), .bout(bout_1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic modulo 2^w.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic bi);
        exp_t        e;
        logic [63:0] mask;
        logic [64:0] subtr;
        mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        a      = a & mask;
        b      = b & mask;
        subtr  = {1'b0, b} + 65'(bi);
        e.diff = (a - b - 64'(bi)) & mask;
        e.bout = ({1'b0, a} < subtr);
        e.acc  = 0;
        return e;
    endfunction

    task automatic drive(input int s, input logic [63:0] a, input logic [63:0] b,
                         input logic bi, input logic st);
        case (s)
            0: begin a_8 = a[7:0]; b_8 = b[7:0]; bin_8 = bi; start_8 = st; end
            1: begin a_4 = a[3:0]; b_4 = b[3:0]; bin_4 = bi; start_4 = st; end
            default: begin a_1 = a[0:0]; b_1 = b[0:0]; bin_1 = bi; start_1 = st; end
        endcase
    endtask

    task automatic push(input int s, input exp_t e);
        case (s)
            0: q8.push_back(e);
            1: q4.push_back(e);
            default: q1.push_back(e);
        endcase
    endtask

    // Issues one accepted start; while busy, optionally toggles start and operands as noise.
    task automatic op(input int s, input logic [63:0] a, input logic [63:0] b,
                      input logic bi, input bit junk);
        exp_t e;
        int   w;
        w = widths[s];
        @(negedge clk);
        drive(s, a, b, bi, 1'b1);
        e = model(w, a, b, bi);
        e.acc = cyc;
        push(s, e);
        for (int i = 1; i <= w + 1; i++) begin
            @(negedge clk);
            if (junk && i <= w)
                drive(s, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            else
                drive(s, 64'd0, 64'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic mon(input int s, input logic dn, input logic [63:0] df, input logic bo,
                       input logic rdy, input logic bsy);
        exp_t  e;
        bit    ok;
        string tag;
        tag = $sformatf("w%0d", widths[s]);
        ok  = 0;
        if (was_done[s]) begin
            check({tag, " done_width"}, 64'(dn), 64'd0);
            check({tag, " ready_after_done"}, 64'(rdy), 64'd1);
        end
        was_done[s] = dn;
        if (dn) begin
            case (s)
                0: if (q8.size() > 0) begin e = q8.pop_front(); ok = 1; end
                1: if (q4.size() > 0) begin e = q4.pop_front(); ok = 1; end
                default: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1; end
            endcase
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected_done: got done=1 required no pending op (cycle %0d)",
                         tag, cyc);
            end else begin
                check({tag, " diff"}, df, e.diff);
                check({tag, " bout"}, 64'(bo), 64'(e.bout));
                check({tag, " latency"}, 64'(cyc - e.acc), 64'(widths[s] + 1));
                check({tag, " busy_in_done"}, 64'(bsy), 64'd1);
                check({tag, " ready_in_done"}, 64'(rdy), 64'd0);
                held_d[s] = e.diff;
                held_b[s] = e.bout;
            end
        end
        check({tag, " diff_hold"}, df, held_d[s]);
        check({tag, " bout_hold"}, 64'(bo), 64'(held_b[s]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, done_8, {56'd0, diff_8}, bout_8, ready_8, busy_8);
            mon(1, done_4, {60'd0, diff_4}, bout_4, ready_4, busy_4);
            mon(2, done_1, {63'd0, diff_1}, bout_1, ready_1, busy_1);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst ready", 64'({ready_8, ready_4, ready_1}), 64'b111);
        check("rst busy", 64'({busy_8, busy_4, busy_1}), 64'b000);
        check("rst done", 64'({done_8, done_4, done_1}), 64'b000);
        check("rst diff8", 64'(diff_8), 64'd0);
        check("rst bout", 64'({bout_8, bout_4, bout_1}), 64'b000);
        rst = 1'b0;

        op(1, 64'd5, 64'd3, 1'b0, 0);
        op(1, 64'd3, 64'd5, 1'b0, 0);
        op(1, 64'd3, 64'd3, 1'b1, 0);
        op(0, 64'h00, 64'h00, 1'b0, 0);
        op(0, 64'h80, 64'h01, 1'b0, 0);
        op(0, 64'h00, 64'h01, 1'b0, 0);
        op(0, 64'h00, 64'h00, 1'b1, 0);
        op(0, 64'hA5, 64'h3C, 1'b1, 1);
        for (int i = 0; i < 8; i++)
            op(2, 64'(i[2]), 64'(i[1]), i[0], 0);

        // Abort in the third RUN cycle; the op must never report done.
        @(negedge clk);
        drive(0, 64'h55, 64'h22, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 64'h00, 64'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("run busy", 64'({busy_8, ready_8}), 64'b10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            held_d[s] = '0;
            held_b[s] = 1'b0;
            was_done[s] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", 64'(ready_8), 64'd1);
        check("abort busy", 64'(busy_8), 64'd0);
        check("abort done", 64'(done_8), 64'd0);
        check("abort diff", 64'(diff_8), 64'd0);
        check("abort bout", 64'(bout_8), 64'd0);
        repeat (12) @(negedge clk);
        op(0, 64'h55, 64'h22, 1'b0, 0);

        for (int i = 0; i < 1000; i++)
            op(0, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 100; i++)
            op(1, 64'($urandom_range(0, 15)), 64'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (30) @(negedge clk);
        check("pending w8", 64'(q8.size()), 64'd0);
        check("pending w4", 64'(q4.size()), 64'd0);
        check("pending w1", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. Computes diff = a - b - bin over WIDTH bits by processing one bit per clock, LSB first. Each bit goes through a single full-subtractor cell built from two half subtractors (D = x^y, B = ~x&y). Uses a start/ready/done handshake, so a datapath can share one 1-bit subtract cell instead of a WIDTH-bit ripple subtractor.

Parameters:
WIDTH, 8, operand width in bits; legal range 1..64.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request; sampled only while ready=1.
a  in  WIDTH  minuend; captured on accepted start.
b  in  WIDTH  subtrahend; captured on accepted start.
bin  in  1  borrow-in for chaining; captured on accepted start.
ready  out  1  high in IDLE only.
busy  out  1  high in RUN and DONE.
done  out  1  one-cycle pulse, result valid.
diff  out  WIDTH  registered difference, held until the next completion.
bout  out  1  registered final borrow, held with diff.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). No async paths.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, internal shift regs, counter and borrow=0.
- rst has priority over all other inputs in the same edge. A reset during RUN or DONE aborts the operation: no done pulse and diff/bout return to 0.
- States:
  - IDLE: ready=1. On start=1, capture a, b, bin into shift regs/borrow reg, set bit counter=0, go to RUN.
  - RUN: each cycle
    - x = a_sh[0], y = b_sh[0], c = borrow.
    - First half subtractor: d1 = x^y, b1 = ~x&y.
    - Second half subtractor: d = d1^c, b2 = ~d1&c.
    - borrow <= b1|b2.
    - Result shift reg shifts in d at MSB (right shift); a_sh and b_sh shift right; counter++.
    - When counter = WIDTH-1 that cycle, go to DONE and load diff from the final result and bout from the final borrow.
  - DONE: done=1 for exactly one cycle; unconditionally go to IDLE.
- Latency: start high in cycle 0 (accepted), RUN in cycles 1..WIDTH, done=1 in cycle WIDTH+1, ready=1 again in cycle WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- start while ready=0 is ignored (not queued). a/b/bin may change freely after acceptance.
- WIDTH=1: single RUN cycle; done in cycle 2.
- Arithmetic is modulo 2^WIDTH. bout=1 iff a < b+bin as unsigned values. Example: 0-0-1 gives diff = all ones, bout=1.
- diff/bout change only on entry to DONE or on reset. They are stable between done pulses.
- ready, busy and done are decoded from registered state. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package sub_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - CNT_W = $clog2(WIDTH) (min 1), provided as a function.
- One sub-module: full_sub_bit, built from two half_subtractor instances plus an OR. It is purely combinational, is instantiated once in the controller, and is unit-testable on its own.

Test Plan:
- WIDTH=4, reset then a=5, b=3, bin=0, start in cycle 0 -> done in cycle 5 only, diff=4'h2, bout=0, ready back in cycle 6.
- WIDTH=4, a=3, b=5, bin=0 -> diff=4'hE, bout=1. Then a=3, b=3, bin=1 -> diff=4'hF, bout=1.
- WIDTH=8, a=8'h00, b=8'h00, bin=0 -> diff=8'h00, bout=0. Then a=8'h80, b=8'h01 -> diff=8'h7F, bout=0. Then a=0, b=8'h01 -> diff=8'hFF, bout=1.
- WIDTH=8, start pulsed and a/b changed during RUN -> second start ignored, result reflects original operands, exactly one done pulse.
- rst asserted in RUN cycle 3 -> next cycle ready=1, busy=0, diff=0, bout=0, no done. A new start then completes normally.
- WIDTH=1, exhaustive a, b, bin (8 cases) -> done in cycle 2, {bout,diff} matches a-b-bin. Plus a random 1000-op WIDTH=8 run against a reference model.
